// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and default widths for mem_arbiter          |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    localparam int c_data_w  = 32;
    localparam int c_addr_w  = 32;
    localparam int c_timeout = 16;

endpackage
`default_nettype wire

// File: rtl/mem_arb_wdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_wdog : saturating BUSY-cycle watchdog for mem_arbiter          |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = c_timeout
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int              c_cw   = $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0] c_max  = c_cw'(TIMEOUT);
    localparam logic [c_cw-1:0] c_last = c_cw'(TIMEOUT - 1);
    localparam logic [c_cw-1:0] c_one  = c_cw'(1);

    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_max)) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    // Expiry is flagged in the cycle whose edge would bring the count to TIMEOUT
    assign o_expired = i_en && (r_cnt >= c_last);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : fetch/data arbiter onto one single-port memory           |
// | Optional: define MEM_ARB_RR_EN for round-robin on simultaneous reqs.   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N       = c_data_w,
    parameter int AW      = c_addr_w,
    parameter int TIMEOUT = c_timeout
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           if_req,
    input  logic [AW-1:0]  if_addr,
    output logic [N-1:0]   if_rdata,
    output logic           if_ack,
    input  logic           d_req,
    input  logic           d_we,
    input  logic [N/8-1:0] d_be,
    input  logic [AW-1:0]  d_addr,
    input  logic [N-1:0]   d_wdata,
    output logic [N-1:0]   d_rdata,
    output logic           d_ack,
    output logic           m_req,
    output logic           m_we,
    output logic [N/8-1:0] m_be,
    output logic [AW-1:0]  m_addr,
    output logic [N-1:0]   m_wdata,
    input  logic [N-1:0]   m_rdata,
    input  logic           m_ack,
    output logic           stall,
    output logic           err
);

    arb_state_t     r_state;
    arb_state_t     w_next_state;
    arb_owner_t     r_owner;
    arb_owner_t     w_pick;
    logic           w_done_ok;
    logic           w_done_to;
    logic           w_expired;
    logic           w_wdog_clr;
    logic           w_wdog_en;
    logic           r_m_we;
    logic [N/8-1:0] r_m_be;
    logic [AW-1:0]  r_m_addr;
    logic [N-1:0]   r_m_wdata;
    logic [N-1:0]   r_if_rdata;
    logic [N-1:0]   r_d_rdata;
    logic           r_err;

    assign w_wdog_clr = (r_state != BUSY);
    assign w_wdog_en  = (r_state == BUSY);

    mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_wdog_clr),
        .i_en      (w_wdog_en),
        .o_expired (w_expired)
    );

`ifdef MEM_ARB_RR_EN
    arb_owner_t r_last_grant;

    // Contention goes to whichever requester was not served last
    always_comb begin
        w_pick = OWN_NONE;
        if (d_req && if_req) begin
            w_pick = (r_last_grant == OWN_D) ? OWN_IF : OWN_D;
        end else if (d_req) begin
            w_pick = OWN_D;
        end else if (if_req) begin
            w_pick = OWN_IF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= OWN_IF;
        end else if ((r_state == IDLE) && (w_pick != OWN_NONE)) begin
            r_last_grant <= w_pick;
        end
    end
`else
    always_comb begin
        w_pick = OWN_NONE;
        if (d_req) begin
            w_pick = OWN_D;
        end else if (if_req) begin
            w_pick = OWN_IF;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // m_ack is tested before expiry so a late ack on the last cycle succeeds
    always_comb begin
        w_next_state = r_state;
        w_done_ok    = 1'b0;
        w_done_to    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick != OWN_NONE) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (m_ack) begin
                    w_done_ok    = 1'b1;
                    w_next_state = RESP;
                end else if (w_expired) begin
                    w_done_to    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_NONE;
            r_m_we     <= 1'b0;
            r_m_be     <= '0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick == OWN_D) begin
                        r_owner   <= OWN_D;
                        r_m_we    <= d_we;
                        r_m_be    <= d_be;
                        r_m_addr  <= d_addr;
                        r_m_wdata <= d_wdata;
                    end else if (w_pick == OWN_IF) begin
                        r_owner   <= OWN_IF;
                        r_m_we    <= 1'b0;
                        r_m_be    <= '1;
                        r_m_addr  <= if_addr;
                        r_m_wdata <= '0;
                    end
                end
                BUSY: begin
                    if (w_done_ok || w_done_to) begin
                        r_err <= w_done_to;
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= w_done_ok ? m_rdata : '0;
                        end
                        if (r_owner == OWN_D) begin
                            r_d_rdata <= (w_done_ok && !r_m_we) ? m_rdata : '0;
                        end
                    end
                end
                RESP: begin
                    r_err   <= 1'b0;
                    r_owner <= OWN_NONE;
                end
                default: ;
            endcase
        end
    end

    assign m_req    = (r_state == BUSY);
    assign m_we     = r_m_we;
    assign m_be     = r_m_be;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign if_ack   = (r_state == RESP) && (r_owner == OWN_IF);
    assign d_ack    = (r_state == RESP) && (r_owner == OWN_D);
    assign err      = r_err;
    assign stall    = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule
`default_nettype wire
